// File: rtl/axi_pkg.sv
// Shared AXI encodings, read-master FSM state type and command-entry sizing.
// Pure declarations: no latency and no backpressure of its own.
// Imported by the read master, its command FIFO and the bench.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [1:0] rm_state_t;
    localparam rm_state_t ST_IDLE = 2'd0;
    localparam rm_state_t ST_ADDR = 2'd1;
    localparam rm_state_t ST_DATA = 2'd2;

    // id + addr + len(4) + size(2) + burst(2); TAG_BITS+40 with a 32-bit bus
    function automatic int cmd_entry_bits(input int tag_bits, input int bus_width);
        return tag_bits + bus_width + 8;
    endfunction

endpackage

// File: rtl/axi_read_master_if.sv
// Command, AR, R and user-data signal bundle for the AXI read master.
// Wires only: no latency; valid/ready handshakes are carried unchanged.
// master = the read-master view, slave = the surrounding system / bench view.
interface axi_read_master_if #(
    parameter int TAG_BITS  = 2,
    parameter int BUS_WIDTH = 32
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [TAG_BITS-1:0]  cmd_id;
    logic [BUS_WIDTH-1:0] cmd_addr;
    logic [3:0]           cmd_len;
    logic [1:0]           cmd_size;
    logic [1:0]           cmd_burst;

    logic [TAG_BITS-1:0]  arid;
    logic [BUS_WIDTH-1:0] araddr;
    logic [3:0]           arlen;
    logic [1:0]           arsize;
    logic [1:0]           arburst;
    logic [1:0]           arlock;
    logic [3:0]           arcache;
    logic [2:0]           arprot;
    logic                 arvalid;
    logic                 arready;

    logic [TAG_BITS-1:0]  rid;
    logic [BUS_WIDTH-1:0] rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    logic [BUS_WIDTH-1:0] dout;
    logic                 dout_valid;
    logic                 dout_last;
    logic [1:0]           dout_resp;
    logic                 dout_ready;

    modport master (
        input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
        output cmd_ready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output dout, dout_valid, dout_last, dout_resp,
        input  dout_ready
    );

    modport slave (
        output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst,
        input  cmd_ready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  dout, dout_valid, dout_last, dout_resp,
        output dout_ready
    );
endinterface

// File: rtl/axi_read_master_cmd_fifo.sv
// rm_cmd_fifo: 2-entry command FIFO with full/empty flags.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module rm_cmd_fifo #(
    parameter int W = 42
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push_ok;
    logic         pop_ok;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/axi_read_master.sv
// AXI read master: queues commands, issues one AR at a time, streams R beats out. Option: READ_MASTER_TIMEOUT_EN.
// Latency: AR valid two cycles after a command push into an idle master; R->dout is combinational.
// Backpressure: cmd_ready drops when both FIFO slots are used; rready follows dout_ready in DATA.
module axi_read_master
    import axi_pkg::*;
#(
    parameter int TAG_BITS  = 2,
    parameter int BUS_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    axi_read_master_if.master   bus,
    output logic                done,
    output logic                err
);
    localparam int ENTRY_W = cmd_entry_bits(TAG_BITS, BUS_WIDTH);

    rm_state_t            state;
    logic [3:0]           beat_cnt;
    logic [TAG_BITS-1:0]  arid_q;
    logic [BUS_WIDTH-1:0] araddr_q;
    logic [3:0]           arlen_q;
    logic [1:0]           arsize_q;
    logic [1:0]           arburst_q;

    logic [ENTRY_W-1:0]   push_dat;
    logic [ENTRY_W-1:0]   head_dat;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 ar_hs;
    logic                 beat_acc;
    logic                 beat_final;
    logic                 proto_err;
    logic                 wd_fire;

    assign push_dat = {bus.cmd_id, bus.cmd_addr, bus.cmd_len, bus.cmd_size, bus.cmd_burst};
    assign pop      = (state == ST_IDLE) && !fifo_empty;

    rm_cmd_fifo #(.W(ENTRY_W)) u_cmd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.cmd_valid && bus.cmd_ready),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign bus.cmd_ready  = !fifo_full;
    assign bus.arvalid    = (state == ST_ADDR);
    assign bus.arid       = arid_q;
    assign bus.araddr     = araddr_q;
    assign bus.arlen      = arlen_q;
    assign bus.arsize     = arsize_q;
    assign bus.arburst    = arburst_q;
    assign bus.arlock     = 2'b00;
    assign bus.arcache    = 4'b0000;
    assign bus.arprot     = 3'b000;
    assign bus.rready     = (state == ST_DATA) && bus.dout_ready;
    assign bus.dout       = bus.rdata;
    assign bus.dout_valid = (state == ST_DATA) && bus.rvalid;
    assign bus.dout_resp  = bus.rresp;
    assign bus.dout_last  = bus.rlast;

    assign ar_hs      = (state == ST_ADDR) && bus.arready;
    assign beat_acc   = (state == ST_DATA) && bus.rvalid && bus.dout_ready;
    assign beat_final = beat_acc && (beat_cnt == arlen_q);
    // Burst length is decided by the beat count; rlast is only cross-checked.
    assign proto_err  = (beat_acc && ((bus.rlast != (beat_cnt == arlen_q)) || (bus.rid != arid_q)))
                     || (bus.rvalid && (state != ST_DATA));

`ifdef READ_MASTER_TIMEOUT_EN
    logic [7:0] wd_cnt;
    assign wd_fire = (wd_cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE) || ar_hs || beat_acc || wd_fire) begin
            wd_cnt <= 8'd0;
        end else begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            beat_cnt  <= 4'd0;
            err       <= 1'b0;
            done      <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= 4'd0;
            arsize_q  <= 2'd0;
            arburst_q <= 2'd0;
        end else begin
            done <= beat_final;
            if (proto_err || wd_fire) err <= 1'b1;
            if (wd_fire) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (!fifo_empty) begin
                        state <= ST_ADDR;
                        {arid_q, araddr_q, arlen_q, arsize_q, arburst_q} <= head_dat;
                    end
                    ST_ADDR: if (ar_hs) begin
                        state    <= ST_DATA;
                        beat_cnt <= 4'd0;
                    end
                    ST_DATA: if (beat_acc) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (beat_cnt == arlen_q) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
